// File: rtl/axil_ctrl_regs_pkg.sv
// Shared types and constants for the AXI4-Lite control register block.
package axil_ctrl_regs_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_DATA = 2'd2,
      W_RESP = 2'd3
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [5:0] RO_ID_IDX     = 6'd0;
   localparam logic [5:0] RO_STATUS_IDX = 6'd1;

endpackage

// File: rtl/axil_addr_decode.sv
// Byte address to register slot decode: index, error and read-only flags.
module axil_addr_decode
   import axil_ctrl_regs_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic [31:0] i_addr,
   output logic [5:0]  o_index,
   output logic        o_err,
   output logic        o_ro
);

   localparam logic [6:0] LP_NUM = 7'(NUM_REGS);

   // Upper address bits alias onto the 256-byte window.
   logic w_unused;
   assign w_unused = ^i_addr[31:8];

   assign o_index = i_addr[7:2];
   assign o_err   = (i_addr[1:0] != 2'b00)
                 || ({1'b0, i_addr[7:2]} >= LP_NUM);
   assign o_ro    = (o_index == RO_ID_IDX)
                 || (o_index == RO_STATUS_IDX);

endmodule

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit control registers.
module axil_ctrl_regs
   import axil_ctrl_regs_pkg::*;
#(
   parameter int          NUM_REGS = 16,
   parameter logic [31:0] ID_VALUE = 32'h4D45_4E31
) (
   input  logic                     axil_aclk,
   input  logic                     axil_rst,
   input  logic                     s_axil_awvalid,
   output logic                     s_axil_awready,
   input  logic [31:0]              s_axil_awaddr,
   input  logic                     s_axil_wvalid,
   output logic                     s_axil_wready,
   input  logic [31:0]              s_axil_wdata,
   output logic                     s_axil_bvalid,
   output logic [1:0]               s_axil_bresp,
   input  logic                     s_axil_bready,
   input  logic                     s_axil_arvalid,
   output logic                     s_axil_arready,
   input  logic [31:0]              s_axil_araddr,
   output logic                     s_axil_rvalid,
   output logic [31:0]              s_axil_rdata,
   output logic [1:0]               s_axil_rresp,
   input  logic                     s_axil_rready,
   input  logic [31:0]              status_in,
   output logic [NUM_REGS*32-1:0]   reg_out,
   output logic [NUM_REGS-1:0]      reg_wr_pulse
);

   wr_state_t   r_wstate;
   logic        r_awready;
   logic        r_wready;
   logic        r_bvalid;
   logic [1:0]  r_bresp;
   logic [31:0] r_awaddr;
   logic [31:0] r_wdata;

   rd_state_t   r_rstate;
   logic        r_arready;
   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;

   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_ar_hs;
   logic        w_commit;
   logic [31:0] w_waddr;
   logic [31:0] w_wdat;
   logic [5:0]  w_widx;
   logic        w_werr;
   logic        w_wro;
   logic        w_wbad;
   logic [5:0]  w_ridx;
   logic        w_rerr;
   logic        w_rro;
   logic [31:0] w_rd_word;
   logic [31:0] w_slots [NUM_REGS];

   assign w_aw_hs = s_axil_awvalid & r_awready;
   assign w_w_hs  = s_axil_wvalid & r_wready;
   assign w_ar_hs = s_axil_arvalid & r_arready;

   // The write commits on the edge that completes the later handshake.
   assign w_commit = ((r_wstate == W_IDLE) & w_aw_hs & w_w_hs)
                   | ((r_wstate == W_ADDR) & w_w_hs)
                   | ((r_wstate == W_DATA) & w_aw_hs);

   assign w_waddr = (r_wstate == W_ADDR) ? r_awaddr : s_axil_awaddr;
   assign w_wdat  = (r_wstate == W_DATA) ? r_wdata : s_axil_wdata;
   assign w_wbad  = w_werr | w_wro;

   axil_addr_decode #(.NUM_REGS(NUM_REGS)) u_wr_dec (
      .i_addr  (w_waddr),
      .o_index (w_widx),
      .o_err   (w_werr),
      .o_ro    (w_wro)
   );

   axil_addr_decode #(.NUM_REGS(NUM_REGS)) u_rd_dec (
      .i_addr  (s_axil_araddr),
      .o_index (w_ridx),
      .o_err   (w_rerr),
      .o_ro    (w_rro)
   );

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
      if (g == 0) begin : g_id
         assign w_slots[g]      = ID_VALUE;
         assign reg_wr_pulse[g] = 1'b0;
      end else if (g == 1) begin : g_status
         assign w_slots[g]      = status_in;
         assign reg_wr_pulse[g] = 1'b0;
      end else begin : g_rw
         logic        w_we;
         logic [31:0] r_val;
         logic        r_pls;
         assign w_we = w_commit & ~w_wbad & (w_widx == 6'(g));
         always_ff @(posedge axil_aclk) begin
            if (axil_rst) begin
               r_val <= '0;
               r_pls <= 1'b0;
            end else begin
               r_pls <= w_we;
               if (w_we) r_val <= w_wdat;
            end
         end
         assign w_slots[g]      = r_val;
         assign reg_wr_pulse[g] = r_pls;
      end
      assign reg_out[g*32 +: 32] = w_slots[g];
   end

   always_ff @(posedge axil_aclk) begin
      if (axil_rst) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_awaddr  <= '0;
         r_wdata   <= '0;
      end else if (w_commit) begin
         r_wstate  <= W_RESP;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b1;
         r_bresp   <= w_wbad ? RESP_SLVERR : RESP_OKAY;
      end else begin
         unique case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_wstate  <= W_ADDR;
                  r_awaddr  <= s_axil_awaddr;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
               end else if (w_w_hs) begin
                  r_wstate  <= W_DATA;
                  r_wdata   <= s_axil_wdata;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b0;
               end else begin
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
            W_ADDR: ;
            W_DATA: ;
            W_RESP: begin
               if (s_axil_bready) begin
                  r_wstate  <= W_IDLE;
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      w_rd_word = 32'd0;
      if (w_rerr) begin
         w_rd_word = 32'd0;
      end else if (w_rro) begin
         w_rd_word = (w_ridx == RO_ID_IDX) ? ID_VALUE : status_in;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ridx == 6'(i)) w_rd_word = w_slots[i];
         end
      end
   end

   always_ff @(posedge axil_aclk) begin
      if (axil_rst) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         unique case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_rstate  <= R_DATA;
                  r_arready <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_rdata   <= w_rd_word;
                  r_rresp   <= w_rerr ? RESP_SLVERR : RESP_OKAY;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axil_rready) begin
                  r_rstate  <= R_IDLE;
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
               end
            end
         endcase
      end
   end

   assign s_axil_awready = r_awready;
   assign s_axil_wready  = r_wready;
   assign s_axil_bvalid  = r_bvalid;
   assign s_axil_bresp   = r_bresp;
   assign s_axil_arready = r_arready;
   assign s_axil_rvalid  = r_rvalid;
   assign s_axil_rdata   = r_rdata;
   assign s_axil_rresp   = r_rresp;

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Scoreboard bench for axil_ctrl_regs: directed AXI-Lite vectors.
module tb_axil_ctrl_regs;

   localparam int          NR  = 16;
   localparam logic [31:0] IDV = 32'h4D45_4E31;
   localparam logic [1:0]  OK  = 2'b00;
   localparam logic [1:0]  ERR = 2'b10;

   logic          clk;
   logic          rst;
   logic          awvalid, awready, wvalid, wready;
   logic [31:0]   awaddr, wdata;
   logic          bvalid, bready;
   logic [1:0]    bresp;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   araddr, rdata;
   logic [1:0]    rresp;
   logic [31:0]   status_in;
   logic [NR*32-1:0] reg_out;
   logic [NR-1:0] reg_wr_pulse;

   int n_pass = 0;
   int n_tot  = 0;
   int pulse_cnt = 0;
   int p0;
   int cnt;

   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];

   axil_ctrl_regs #(.NUM_REGS(NR), .ID_VALUE(IDV)) dut (
      .axil_aclk      (clk),
      .axil_rst       (rst),
      .s_axil_awvalid (awvalid),
      .s_axil_awready (awready),
      .s_axil_awaddr  (awaddr),
      .s_axil_wvalid  (wvalid),
      .s_axil_wready  (wready),
      .s_axil_wdata   (wdata),
      .s_axil_bvalid  (bvalid),
      .s_axil_bresp   (bresp),
      .s_axil_bready  (bready),
      .s_axil_arvalid (arvalid),
      .s_axil_arready (arready),
      .s_axil_araddr  (araddr),
      .s_axil_rvalid  (rvalid),
      .s_axil_rdata   (rdata),
      .s_axil_rresp   (rresp),
      .s_axil_rready  (rready),
      .status_in      (status_in),
      .reg_out        (reg_out),
      .reg_wr_pulse   (reg_wr_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endfunction

   function automatic logic [31:0] slot(int i);
      return reg_out[i*32 +: 32];
   endfunction

   // Monitor: pops expected responses on every B/R handshake.
   always @(negedge clk) begin
      pulse_cnt <= pulse_cnt + $countones(reg_wr_pulse);
      if (bvalid && bready) begin
         if (exp_b.size() == 0) begin
            chk("b_unexpected", 32'(bresp), 32'hFFFF_FFFF);
         end else begin
            chk("bresp", 32'(bresp), 32'(exp_b[0]));
            void'(exp_b.pop_front());
         end
      end
      if (rvalid && rready) begin
         if (exp_r.size() == 0) begin
            chk("r_unexpected", rdata, 32'hFFFF_FFFF);
         end else begin
            chk("rdata", rdata, exp_r[0][31:0]);
            chk("rresp", 32'(rresp), 32'(exp_r[0][33:32]));
            void'(exp_r.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] er);
      bit ag, wg, done;
      exp_b.push_back(er);
      awaddr = a; wdata = d;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
         @(negedge clk);
         ag = awvalid && awready;
         wg = wvalid && wready;
         tick();
         if (ag) awvalid = 1'b0;
         if (wg) wvalid = 1'b0;
      end
      if (awvalid || wvalid) begin
         chk("wr_accept_timeout", 32'd0, 32'd1);
         awvalid = 1'b0; wvalid = 1'b0;
      end
      done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         done = bvalid;
         tick();
      end
      if (!done) chk("wr_resp_timeout", 32'd0, 32'd1);
      bready = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] er);
      bit ag, done;
      exp_r.push_back({er, d});
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      ag = 1'b0;
      for (int n = 0; n < 20 && !ag; n++) begin
         @(negedge clk);
         ag = arready;
         tick();
      end
      arvalid = 1'b0;
      if (!ag) chk("rd_accept_timeout", 32'd0, 32'd1);
      done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         done = rvalid;
         tick();
      end
      if (!done) chk("rd_resp_timeout", 32'd0, 32'd1);
      rready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b0; rready = 1'b0;
      awaddr = '0; wdata = '0; araddr = '0;
      status_in = 32'h600D_F00D;
      repeat (3) tick();

      @(negedge clk);
      chk("rst_ready", 32'({awready, wready, arready}), 32'd0);
      chk("rst_valid", 32'({bvalid, rvalid}), 32'd0);
      chk("rst_resp", 32'({bresp, rresp}), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_pulse", 32'(reg_wr_pulse), 32'd0);
      chk("rst_slot2", slot(2), 32'd0);
      chk("rst_slot0_id", slot(0), IDV);
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk("ready_rise", 32'({awready, wready, arready}), 32'd7);
      tick();

      // AW and W together
      p0 = pulse_cnt;
      exp_b.push_back(OK);
      awaddr = 32'h08; wdata = 32'hDEAD_BEEF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      chk("aw_w_ready", 32'({awready, wready}), 32'd3);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      chk("b_latency", 32'(bvalid), 32'd1);
      chk("pulse_slot2", 32'(reg_wr_pulse), 32'h4);
      chk("slot2", slot(2), 32'hDEAD_BEEF);
      tick();
      bready = 1'b1;
      @(negedge clk);
      chk("pulse_one_cycle", 32'(reg_wr_pulse), 32'd0);
      tick();
      bready = 1'b0;
      @(negedge clk);
      chk("b_cleared", 32'(bvalid), 32'd0);
      tick();
      chk("pulse_cnt_w1", 32'(pulse_cnt - p0), 32'd1);

      // AW first, W five cycles later, bready held low
      exp_b.push_back(OK);
      awaddr = 32'h0C; awvalid = 1'b1;
      @(negedge clk);
      chk("aw_alone_ready", 32'(awready), 32'd1);
      tick();
      awvalid = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("w_addr_ready", 32'({awready, wready}), 32'd1);
      tick();
      wdata = 32'h1234; wvalid = 1'b1;
      @(negedge clk);
      chk("w_late_ready", 32'(wready), 32'd1);
      tick();
      wvalid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bvalid && !awready && !wready) cnt++;
         tick();
      end
      chk("b_hold10", 32'(cnt), 32'd10);
      bready = 1'b1;
      @(negedge clk);
      chk("slot3", slot(3), 32'h1234);
      tick();
      bready = 1'b0;

      // Error and read-only writes, error reads
      p0 = pulse_cnt;
      wr(32'h00, 32'h1111_1111, ERR);
      wr(32'h04, 32'h2222_2222, ERR);
      wr(32'h06, 32'h3333_3333, ERR);
      wr(32'h0A, 32'h4444_4444, ERR);
      wr(32'h40, 32'h5555_5555, ERR);
      tick();
      chk("err_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      chk("slot2_kept", slot(2), 32'hDEAD_BEEF);
      chk("slot1_status", slot(1), 32'h600D_F00D);
      chk("slot0_id", slot(0), IDV);
      rd(32'h00, IDV, OK);
      rd(32'h40, 32'd0, ERR);
      rd(32'h06, 32'd0, ERR);
      rd(32'h08, 32'hDEAD_BEEF, OK);
      rd(32'h0C, 32'h1234, OK);
      wr(32'h3C, 32'hF00F_0FF0, OK);
      rd(32'h3C, 32'hF00F_0FF0, OK);

      // Status sampled at handshake, rdata held while rready low
      status_in = 32'hA5A5_A5A5;
      exp_r.push_back({OK, 32'hA5A5_A5A5});
      araddr = 32'h04; arvalid = 1'b1;
      @(negedge clk);
      chk("ar_ready", 32'(arready), 32'd1);
      tick();
      arvalid = 1'b0;
      status_in = 32'h0;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rvalid && !arready && rdata == 32'hA5A5_A5A5) cnt++;
         tick();
      end
      chk("r_hold3", 32'(cnt), 32'd3);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      @(negedge clk);
      chk("r_cleared", 32'(rvalid), 32'd0);
      tick();

      // Read and write of slot 4 on the same edge
      wr(32'h10, 32'd1, OK);
      exp_b.push_back(OK);
      exp_r.push_back({OK, 32'd1});
      awaddr = 32'h10; wdata = 32'd2; araddr = 32'h10;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(negedge clk);
      chk("all_ready", 32'({awready, wready, arready}), 32'd7);
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      chk("b_r_both", 32'({bvalid, rvalid}), 32'd3);
      tick();
      bready = 1'b0; rready = 1'b0;
      chk("slot4_after", slot(4), 32'd2);

      // Reset while an address is held
      p0 = pulse_cnt;
      awaddr = 32'h14; awvalid = 1'b1;
      @(negedge clk);
      chk("aw_pre_rst", 32'(awready), 32'd1);
      tick();
      awvalid = 1'b0;
      @(negedge clk);
      chk("in_w_addr", 32'({awready, wready}), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("rst_mid_outs", 32'({awready, wready, arready, bvalid}),
          32'd0);
      chk("rst_mid_slots", slot(2) | slot(3) | slot(4) | slot(15),
          32'd0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("no_b_after_rst", 32'(bvalid), 32'd0);
      chk("slot5_zero", slot(5), 32'd0);
      tick();
      tick();
      chk("rst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      wr(32'h14, 32'hCAFE_F00D, OK);
      tick();
      chk("slot5_fresh", slot(5), 32'hCAFE_F00D);
      chk("fresh_pulse", 32'(pulse_cnt - p0), 32'd1);
      rd(32'h14, 32'hCAFE_F00D, OK);

      repeat (3) tick();
      chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
      chk("r_queue_empty", 32'(exp_r.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
